// File: rtl/opb_reg_pkg.sv
// Shared constants for the Simulink-to-PPC OPB register block:
// register word offsets, FSM state encoding and the STATUS word layout.
package opb_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS: capture count in the upper half, fresh flag in bit 0.
  function automatic logic [31:0] status_word(input logic [15:0] count, input logic fresh);
    return {count, 15'd0, fresh};
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side bus bundle; bit 0 of each vector is the MSB, as on the OPB.
interface opb_register_simulink2ppc_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [0:AW-1]   OPB_ABus;
  logic [0:DW/8-1] OPB_BE;
  logic [0:DW-1]   OPB_DBus;
  logic            OPB_RNW;
  logic            OPB_select;
  logic            OPB_seqAddr;
  logic [0:DW-1]   Sl_DBus;
  logic            Sl_xferAck;
  logic            Sl_errAck;
  logic            Sl_retry;
  logic            Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

endinterface

// File: rtl/opb_addr_decode.sv
// Window decode: a hit is a selected address inside [C_BASEADDR, C_HIGHADDR];
// the register offset is the word index within a 16-byte block.
module opb_addr_decode #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E500,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E5FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic [0:C_OPB_AWIDTH-1] addr_i,
  input  logic                    select_i,
  output logic                    hit_o,
  output logic [1:0]              offset_o
);

  assign hit_o    = select_i && (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
  assign offset_o = addr_i[C_OPB_AWIDTH-4 : C_OPB_AWIDTH-3];

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a captured fabric word (DATA), a capture counter with
// fresh flag (STATUS) and a clear control (CTRL) to the PowerPC.
module opb_register_simulink2ppc
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E500,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E5FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                            OPB_Clk,
  input  logic                            OPB_Rst,
  opb_register_simulink2ppc_if.slave      opb,
  input  logic [31:0]                     user_data_in,
  input  logic                            user_data_valid
);

  logic        hit;
  logic [1:0]  offset;

  state_e      state_q;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [1:0]  op_q;
  logic        rnw_q;
  logic        ctrl_bit_q;

  logic [31:0] data_q, data_d;
  logic [15:0] count_q, count_d;
  logic        fresh_q, fresh_d;

  logic [31:0] read_word;
  logic        in_ack;
  logic        clr_all;
  logic        clr_fresh;

  opb_addr_decode #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH)
  ) u_decode (
    .addr_i   (opb.OPB_ABus),
    .select_i (opb.OPB_select),
    .hit_o    (hit),
    .offset_o (offset)
  );

  always_comb begin
    read_word = '0;
    case (offset)
      OFF_DATA:   read_word = data_q;
      OFF_STATUS: read_word = status_word(count_q, fresh_q);
      default:    read_word = '0;
    endcase
  end

  // Side effects of a transfer land in its ACK cycle; a same-cycle capture wins.
  assign in_ack    = (state_q == ST_ACK);
  assign clr_all   = in_ack && !rnw_q && (op_q == OFF_CTRL) && ctrl_bit_q;
  assign clr_fresh = in_ack &&  rnw_q && (op_q == OFF_DATA);

  always_comb begin
    data_d  = data_q;
    count_d = clr_all ? 16'd0 : count_q;
    fresh_d = fresh_q && !(clr_all || clr_fresh);
    if (user_data_valid) begin
      data_d  = user_data_in;
      count_d = count_d + 16'd1;
      fresh_d = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      data_q  <= '0;
      count_q <= '0;
      fresh_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      fresh_q <= fresh_d;
    end
  end

  // Read data is snapshotted on entry to ACK so it cannot change under the master.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      op_q       <= OFF_DATA;
      rnw_q      <= 1'b0;
      ctrl_bit_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            state_q    <= ST_ACK;
            ack_q      <= 1'b1;
            rdata_q    <= opb.OPB_RNW ? read_word : 32'd0;
            op_q       <= offset;
            rnw_q      <= opb.OPB_RNW;
            ctrl_bit_q <= opb.OPB_DBus[C_OPB_DWIDTH-1];
          end
        end
        ST_ACK:  state_q <= ST_HOLD;
        ST_HOLD: if (!opb.OPB_select) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: a register-level model predicts
// every ack/read-data cycle, and literal expectations pin the model.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0100E500;
  localparam logic [31:0] HIGH = 32'h0100E5FF;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] userData = '0;
  logic        userValid = 1'b0;

  opb_register_simulink2ppc_if bus ();

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rstN),
    .opb             (bus),
    .user_data_in    (userData),
    .user_data_valid (userValid)
  );

  int checks = 0;
  int passes = 0;
  int ackSeen = 0;
  bit checkOn = 1'b0;

  logic [31:0] mData  = '0;
  int          mCount = 0;
  bit          mFresh = 1'b0;

  bit          expAck  = 1'b0;
  logic [31:0] expDBus = '0;

  logic [31:0] got;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("xferAck", {31'd0, bus.Sl_xferAck}, {31'd0, expAck});
      checkOutput("Sl_DBus", bus.Sl_DBus, expAck ? expDBus : 32'd0);
      checkOutput("constOuts", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
      if (bus.Sl_xferAck === 1'b1) ackSeen++;
    end
  end

  // One clock edge: the model absorbs any capture the DUT sampled at that edge.
  task automatic step();
    @(posedge clk);
    if (rstN && userValid) begin
      mData  = userData;
      mFresh = 1'b1;
      mCount = (mCount + 1) % 65536;
    end
    #1;
  endtask

  task automatic strobe(input logic [31:0] d, input int n);
    userData  = d;
    userValid = 1'b1;
    repeat (n) step();
    userValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input bit rnw, input logic [31:0] wdata,
                               input bit capInAck, input logic [31:0] capData,
                               input int holdCycles, output logic [31:0] rd);
    int          acksBefore;
    bit          hitExp;
    int          off;
    logic [31:0] snap;
    hitExp = (addr >= BASE) && (addr <= HIGH);
    off    = int'(addr[3:2]);
    snap   = 32'd0;
    if (rnw && off == 0) snap = mData;
    if (rnw && off == 1) snap = {mCount[15:0], 15'd0, mFresh};
    acksBefore = ackSeen;
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = wdata;
    bus.OPB_select = 1'b1;
    expAck = 1'b0;
    step();
    expAck  = hitExp;
    expDBus = snap;
    if (holdCycles == 0) bus.OPB_select = 1'b0;
    if (capInAck) begin
      userData  = capData;
      userValid = 1'b1;
    end
    if (hitExp && rnw && off == 0) mFresh = 1'b0;
    if (hitExp && !rnw && off == 2 && wdata[0]) begin
      mCount = 0;
      mFresh = 1'b0;
    end
    @(negedge clk);
    rd = bus.Sl_DBus;
    step();
    userValid = 1'b0;
    expAck    = 1'b0;
    repeat (holdCycles) step();
    bus.OPB_select = 1'b0;
    step();
    step();
    checkOutput("ackCount", ackSeen - acksBefore, hitExp ? 32'd1 : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #1 checkOn = 1'b1;
    repeat (3) step();
    rstN = 1'b1;
    step();

    $display("[TB] reset read");
    applyStimulus(BASE, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("resetRead", got, 32'h00000000);

    $display("[TB] capture and read");
    strobe(32'hDEADBEEF, 1);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("statusFresh", got, 32'h00010001);
    applyStimulus(BASE, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("dataRead", got, 32'hDEADBEEF);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("statusStale", got, 32'h00010000);

    $display("[TB] no-effect accesses");
    applyStimulus(BASE + 8, 1'b0, 32'h80000000, 1'b0, '0, 0, got);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("ctrlMsbNoClear", got, 32'h00010000);
    applyStimulus(BASE, 1'b0, 32'hFFFFFFFF, 1'b0, '0, 0, got);
    applyStimulus(BASE + 12, 1'b0, 32'h00000001, 1'b0, '0, 0, got);
    applyStimulus(BASE, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("dataAfterWrite", got, 32'hDEADBEEF);
    applyStimulus(BASE + 8, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("ctrlRead", got, 32'h00000000);
    applyStimulus(BASE + 12, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("rsvdRead", got, 32'h00000000);

    $display("[TB] ctrl clear with capture");
    applyStimulus(BASE + 8, 1'b0, 32'h00000001, 1'b1, 32'hCAFEF00D, 0, got);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("clearSetWins", got, 32'h00010001);
    applyStimulus(BASE, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("dataAfterClear", got, 32'hCAFEF00D);

    $display("[TB] snapshot");
    applyStimulus(BASE, 1'b1, '0, 1'b1, 32'h12345678, 0, got);
    checkOutput("snapshotOld", got, 32'hCAFEF00D);
    applyStimulus(BASE, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("snapshotNew", got, 32'h12345678);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("statusAfterSnap", got, 32'h00020000);

    $display("[TB] misses and held select");
    applyStimulus(32'h0100E600, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("missAbove", got, 32'h00000000);
    applyStimulus(32'h0100E4FC, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("missBelow", got, 32'h00000000);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 4, got);
    checkOutput("heldSelect", got, 32'h00020000);
    applyStimulus(HIGH - 3, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("topOfWindow", got, 32'h00000000);

    $display("[TB] count wrap");
    applyStimulus(BASE + 8, 1'b0, 32'h00000001, 1'b0, '0, 0, got);
    strobe(32'hA5A5A5A5, 65536);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("wrapZero", got, 32'h00000001);
    strobe(32'h5A5A5A5A, 1);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("wrapOne", got, 32'h00010001);

    $display("[TB] reset mid-transfer");
    begin
      int acksBefore;
      acksBefore = ackSeen;
      bus.OPB_ABus   = BASE;
      bus.OPB_RNW    = 1'b1;
      bus.OPB_select = 1'b1;
      #2 rstN = 1'b0;
      mData  = '0;
      mCount = 0;
      mFresh = 1'b0;
      step();
      bus.OPB_select = 1'b0;
      step();
      rstN = 1'b1;
      repeat (3) step();
      checkOutput("abortNoAck", ackSeen - acksBefore, 32'd0);
    end
    applyStimulus(BASE, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("dataAfterReset", got, 32'h00000000);
    applyStimulus(BASE + 4, 1'b1, '0, 1'b0, '0, 0, got);
    checkOutput("statusAfterReset", got, 32'h00000000);

    checkOn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0100E500, first byte address of the slave window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0100E5FF, last byte address of the window.
REQ-003 SHALL have parameters C_OPB_AWIDTH, default 32, and C_OPB_DWIDTH, default 32, giving the OPB address and data widths.
REQ-004 SHALL have parameter C_FAMILY, default "virtex6", informational only.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; every other port is synchronous to OPB_Clk.
REQ-006 OPB_Clk  in  1  sole clock.
REQ-007 OPB_Rst  in  1  asynchronous, active-low reset.
REQ-008 OPB_ABus  in  [0:31]  address; bit 0 is the MSB.
REQ-009 OPB_BE  in  [0:3]  byte enables; ignored.
REQ-010 OPB_DBus  in  [0:31]  write data.
REQ-011 OPB_RNW  in  1  1 = read, 0 = write.
REQ-012 OPB_select  in  1  transfer request.
REQ-013 OPB_seqAddr  in  1  ignored.
REQ-014 Sl_DBus  out  [0:31]  read data; all zero except in the ACK cycle.
REQ-015 Sl_xferAck  out  1  transfer acknowledge.
REQ-016 Sl_errAck, Sl_retry and Sl_toutSup  out  1 each  held at constant 0.
REQ-017 user_data_in  in  [31:0]  fabric data.
REQ-018 user_data_valid  in  1  capture strobe for user_data_in.

Function
REQ-019 Bit mapping SHALL be Sl_DBus[i] = reg[31-i], and OPB_DBus[i] maps to reg[31-i].
REQ-020 A hit SHALL be OPB_select=1 with C_BASEADDR <= OPB_ABus <= C_HIGHADDR; the word offset is OPB_ABus[28:29].
REQ-021 Offset 0x0 (DATA) SHALL be read-only and return the last captured user_data_in.
REQ-022 Offset 0x4 (STATUS) SHALL be read-only: [31:16] = capture count, [15:1] = 0, [0] = fresh flag.
REQ-023 Offset 0x8 (CTRL) SHALL clear the count and the fresh flag on a write with reg[0]=1; a read of CTRL returns 0.
REQ-024 Offset 0xC and writes to DATA or STATUS SHALL be acknowledged with no effect; reads of 0xC return 0.
REQ-025 A cycle with user_data_valid=1 SHALL load DATA, set fresh, and increment the count modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-026 The FSM SHALL have states IDLE, ACK and HOLD.
REQ-027 IDLE->ACK on a hit; ACK->HOLD always; HOLD->IDLE when OPB_select=0.
REQ-028 Sl_xferAck SHALL be 1 only in ACK, giving exactly one pulse per transfer, one cycle after the hit is sampled.
REQ-029 Read data SHALL be a snapshot registered on the IDLE->ACK edge; a capture in the ACK cycle does not alter the returned word.
REQ-030 A DATA read SHALL clear fresh in the ACK cycle; if user_data_valid=1 in that same cycle, set wins.
REQ-031 A CTRL clear SHALL take effect in the ACK cycle; if user_data_valid=1 in that same cycle, the count becomes 1 and fresh becomes 1.
REQ-032 A non-hit OPB_select SHALL produce no response.

Reset
REQ-033 While OPB_Rst=0: FSM=IDLE, DATA=0, count=0, fresh=0, Sl_DBus=0, Sl_xferAck=0.
REQ-034 Reset mid-transfer SHALL abort with no acknowledge; after release the FSM restarts from IDLE.

Structure
REQ-035 Offset constants and FSM state encodings SHALL live in shared package opb_reg_pkg.
REQ-036 Address decode SHALL be a sub-module, opb_addr_decode, parameterised by C_BASEADDR and C_HIGHADDR.

Verification
REQ-037 Reset check: after reset release, read 0x0100E500 -> 0x00000000 with one xferAck pulse.
REQ-038 Capture and read: user_data_valid with user_data_in=0xDEADBEEF, then read DATA -> 0xDEADBEEF; then STATUS -> 0x00010001 before the DATA read, 0x00010000 after it.
REQ-039 Count wrap: 65536 strobes -> STATUS[31:16]=0x0000; one more strobe -> 0x0001.
REQ-040 CTRL clear: write 0x00000001 to 0x0100E508, with user_data_valid=1 in the ACK cycle -> STATUS=0x00010001.
REQ-041 Snapshot: in the ACK cycle of a DATA read, capture 0x12345678 -> the read returns the old value; the next DATA read returns 0x12345678.
REQ-042 Misses: select to 0x0100E600 -> no xferAck and Sl_DBus=0; holding select through HOLD -> exactly one ack.
